// File: rtl/register_scan_reader.sv
// register_scan_reader: print-side read master for the register file.
// On start it takes the register-file address path (sel_print=1, read_R), walks the
// register range first_reg..last_reg (5-bit wrapping) and streams each captured value
// to the print module over a valid/ready handshake, then releases the path and pulses done.
// Optional feature macro: REG_SCAN_SKIP_ZERO_EN -- registers that read as zero are not
// emitted; the scan advances as if the entry had been accepted.
module register_scan_reader #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [4:0]        first_reg,
  input  logic [4:0]        last_reg,
  output logic              sel_print,
  output logic [4:0]        read_R,
  input  logic [DATA_W-1:0] reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

`ifdef REG_SCAN_SKIP_ZERO_EN
  localparam bit SkipZero = 1'b1;
`else
  localparam bit SkipZero = 1'b0;
`endif

  // Wait counter reload; READ_LAT is limited to 1..3 so two bits suffice.
  localparam logic [1:0] LatInit = 2'(READ_LAT - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StSend, StFin} state_e;

  state_e     state_q;
  logic [4:0] cur_q;
  logic [4:0] last_q;
  logic [1:0] wait_cnt_q;

  // Scan FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      last_q     <= '0;
      wait_cnt_q <= '0;
      sel_print  <= 1'b0;
      read_R     <= '0;
      out_valid  <= 1'b0;
      out_reg    <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_q     <= first_reg;
            last_q    <= last_reg;
            read_R    <= first_reg;
            sel_print <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          wait_cnt_q <= LatInit;
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_cnt_q != 2'd0) begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end else if (SkipZero && (reg_data == '0)) begin
            // Zero entry is dropped: advance exactly as an accepted handshake would.
            if (cur_q == last_q) begin
              done    <= 1'b1;
              state_q <= StFin;
            end else begin
              cur_q   <= cur_q + 5'd1;
              read_R  <= cur_q + 5'd1;
              state_q <= StAddr;
            end
          end else begin
            out_data  <= reg_data;
            out_reg   <= cur_q;
            out_valid <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cur_q == last_q) begin
              done    <= 1'b1;
              state_q <= StFin;
            end else begin
              cur_q   <= cur_q + 5'd1;
              read_R  <= cur_q + 5'd1;
              state_q <= StAddr;
            end
          end
        end
        StFin: begin
          // done is high during this cycle; the address path is released on exit.
          sel_print <= 1'b0;
          busy      <= 1'b0;
          read_R    <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
